// File: rtl/byte_serializer.sv
// Parallel-to-serial transmitter: takes a WIDTH-bit word on a valid/ready load and
// streams it one bit per enabled clock. Optional parity stage: BYTE_SERIALIZER_PARITY_EN.
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

`ifdef BYTE_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;
  logic             last_bit;
  logic             accept;

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // Handshake: a word transfers on a rising edge where load_valid & load_ready;
  // load_ready never depends on load_valid. Reload is offered on the final bit of a
  // frame (last data bit, or the parity bit) so consecutive words run gap-free.
  assign last_bit   = (state == SHIFT) && (count == LAST);
  assign load_ready = enable && ((state == IDLE) || (last_bit && !PAR_EN) || (state == PARITY));
  assign accept     = load_ready && load_valid;
  assign dbg_state  = state;

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= IDLE;
      count      <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (enable) begin
      if (accept) begin
        state      <= SHIFT;
        count      <= '0;
        sout       <= head(din);
        shreg      <= advance(din);
        par_bit    <= ^din;
        sout_valid <= 1'b1;
        busy       <= 1'b1;
        done       <= 1'b0;
      end else begin
        case (state)
          SHIFT: begin
            if (count == LAST) begin
              if (PAR_EN) begin
                state <= PARITY;
                sout  <= par_bit;
                done  <= 1'b1;
              end else begin
                state      <= IDLE;
                sout       <= 1'b0;
                sout_valid <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
              end
            end else begin
              count <= count + 1'b1;
              sout  <= head(shreg);
              shreg <= advance(shreg);
              // done rides with the last data bit only when no parity bit follows
              done  <= (count == LAST - 1'b1) && !PAR_EN;
            end
          end
          default: begin
            state      <= IDLE;
            count      <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: MSB-first and LSB-first instances share stimulus and are
// compared each cycle against a queue of pending {done,bit} frames.
module tb_byte_serializer;

  localparam int W = 8;
`ifdef BYTE_SERIALIZER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int FRAME = W + (PAR_EN ? 1 : 0);

  logic         clk;
  logic         clear;
  logic         enable;
  logic [W-1:0] din;
  logic         load_valid;

  logic       m_load_ready, m_sout, m_sout_valid, m_busy, m_done;
  logic [1:0] m_dbg_state;
  logic       l_load_ready, l_sout, l_sout_valid, l_busy, l_done;
  logic [1:0] l_dbg_state;

  byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .clear(clear), .enable(enable), .din(din), .load_valid(load_valid),
    .load_ready(m_load_ready), .sout(m_sout), .sout_valid(m_sout_valid),
    .busy(m_busy), .done(m_done), .dbg_state(m_dbg_state)
  );

  byte_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .enable(enable), .din(din), .load_valid(load_valid),
    .load_ready(l_load_ready), .sout(l_sout), .sout_valid(l_sout_valid),
    .busy(l_busy), .done(l_done), .dbg_state(l_dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: bits still to appear on sout, front = bit on sout now, {done,bit}
  logic [1:0] exp_q_msb[$];
  logic [1:0] exp_q_lsb[$];
  int  checks = 0;
  int  errors = 0;
  int  sent_bits = 0;
  int  done_cnt = 0;
  bit  known = 1'b0;
  bit  acc = 1'b0;

  task automatic chk(input string tag, input logic act, input logic exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, act, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int act, input int exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      exp_q_msb.push_back({(i == W - 1) && !PAR_EN, w[W-1-i]});
      exp_q_lsb.push_back({(i == W - 1) && !PAR_EN, w[i]});
    end
    if (PAR_EN) begin
      exp_q_msb.push_back({1'b1, ^w});
      exp_q_lsb.push_back({1'b1, ^w});
    end
  endtask

  task automatic check_outputs();
    int n;
    logic [1:0] fm;
    logic [1:0] fl;
    n  = exp_q_msb.size();
    fm = (n > 0) ? exp_q_msb[0] : 2'b00;
    fl = (exp_q_lsb.size() > 0) ? exp_q_lsb[0] : 2'b00;
    chk("sout_valid", m_sout_valid, n > 0);
    chk("busy", m_busy, n > 0);
    chk("sout_msb", m_sout, fm[0]);
    chk("done", m_done, fm[1]);
    chk("load_ready", m_load_ready, enable && (n <= 1));
    chk("sout_lsb", l_sout, fl[0]);
    chk("sout_valid_lsb", l_sout_valid, n > 0);
    chk("done_lsb", l_done, fl[1]);
    chk("load_ready_lsb", l_load_ready, enable && (n <= 1));
    if (m_sout_valid && enable && !clear) sent_bits++;
    if (m_done && enable && !clear) done_cnt++;
  endtask

  // driver: one clock cycle of stimulus, check, then advance the model at the edge
  task automatic step(input logic clr, input logic en, input logic lv, input logic [W-1:0] d);
    bit rdy;
    @(negedge clk);
    clear = clr; enable = en; load_valid = lv; din = d;
    #1;
    if (known) check_outputs();
    rdy = en && (exp_q_msb.size() <= 1);
    acc = 1'b0;
    @(posedge clk);
    if (clr) begin
      exp_q_msb.delete();
      exp_q_lsb.delete();
      known = 1'b1;
    end else if (en) begin
      if (exp_q_msb.size() > 0) begin
        void'(exp_q_msb.pop_front());
        void'(exp_q_lsb.pop_front());
      end
      if (lv && rdy) begin
        push_word(d);
        acc = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, W'($urandom));
  endtask

  initial begin
    clear = 1'b1; enable = 1'b0; load_valid = 1'b0; din = '0;

    // reset with arbitrary inputs; clear beats enable and load
    step(1'b1, 1'b1, 1'b1, W'($urandom));
    step(1'b1, 1'b0, 1'b1, W'($urandom));
    step(1'b1, 1'b1, 1'b1, W'($urandom));
    #1;
    chk_int("reset_state", int'(m_dbg_state), 0);

    // single word, MSB first
    sent_bits = 0; done_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    idle(FRAME + 2);
    chk_int("t2_bits", sent_bits, FRAME);
    chk_int("t2_done", done_cnt, 1);

    // back-to-back words with load_valid held
    sent_bits = 0; done_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    acc = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'hC3);
      if (acc) break;
    end
    chk("t3_second_accept", acc, 1'b1);
    idle(FRAME + 1);
    chk_int("t3_bits", sent_bits, 2 * FRAME);
    chk_int("t3_done", done_cnt, 2);

    // enable gap after the third bit
    sent_bits = 0; done_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 8'hA5);
    idle(3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, W'($urandom));
    idle(FRAME);
    chk_int("t4_bits", sent_bits, FRAME);
    chk_int("t4_done", done_cnt, 1);

    // clear on the fifth bit, then a clean word
    sent_bits = 0; done_cnt = 0;
    step(1'b0, 1'b1, 1'b1, 8'hFF);
    idle(4);
    step(1'b1, 1'b1, 1'b0, W'($urandom));
    step(1'b0, 1'b1, 1'b1, 8'h81);
    idle(FRAME + 1);
    chk_int("t5_bits", sent_bits, 4 + FRAME);
    chk_int("t5_done", done_cnt, 1);

    // parity-relevant words and a lone low bit for the LSB-first instance
    step(1'b0, 1'b1, 1'b1, 8'h07);
    idle(FRAME + 1);
    step(1'b0, 1'b1, 1'b1, 8'h01);
    idle(FRAME + 1);

    // randomized traffic with enable stalls and rare clears
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 2) != 0), W'($urandom));
    end
    idle(FRAME + 2);
    chk_int("final_idle", exp_q_msb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
